mem_port_arbiter: RTL

- Shares the single-port synchronous data RAM between two requesters: the CPU load/store path and the peripheral/game-module bus master.
- Grants one access per cycle using round-robin with a bounded burst. Muxes the granted request onto the RAM port and steers read data back with fixed one-cycle latency.
- Sits between the CPU write-back/load path and the data RAM.

---
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin, burst-bounded sharing of the data RAM port between CPU and peripheral master
// Define MEM_PORT_ARBITER_LOCK_EN to add cpu_lock (atomic read-modify-write hold of the bus).
module mem_port_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
`ifdef MEM_PORT_ARBITER_LOCK_EN
    input  logic              cpu_lock,
`endif
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              per_req,
    input  logic              per_we,
    input  logic [ADDR_W-1:0] per_addr,
    input  logic [DATA_W-1:0] per_wdata,
    output logic              per_gnt,
    output logic              per_rvalid,
    output logic [DATA_W-1:0] per_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, OWN_CPU, OWN_PER} state_t;

    localparam logic [3:0] BURST_LIM = 4'(MAX_BURST - 1);

    state_t     state, state_nxt;
    logic [3:0] burst_cnt, burst_nxt, burst_inc;
    logic       last_per;
    logic       cpu_rd_pend, per_rd_pend;
    logic       grant_cpu, grant_per, locked;

    assign burst_inc = (burst_cnt == 4'hF) ? 4'hF : burst_cnt + 4'h1;

    // Grants are suppressed while reset is held so the RAM never sees a strobe.
    always_comb begin
        locked    = 1'b0;
`ifdef MEM_PORT_ARBITER_LOCK_EN
        locked    = (state == OWN_CPU) && cpu_lock;
`endif
        grant_cpu = 1'b0;
        grant_per = 1'b0;
        if (reset) begin
            if (locked) begin
                grant_cpu = cpu_req;
            end else if (cpu_req && per_req) begin
                case (state)
                    OWN_CPU: begin
                        if (burst_cnt < BURST_LIM) grant_cpu = 1'b1;
                        else                       grant_per = 1'b1;
                    end
                    OWN_PER: begin
                        if (burst_cnt < BURST_LIM) grant_per = 1'b1;
                        else                       grant_cpu = 1'b1;
                    end
                    default: begin
                        if (last_per) grant_cpu = 1'b1;
                        else          grant_per = 1'b1;
                    end
                endcase
            end else begin
                grant_cpu = cpu_req;
                grant_per = per_req;
            end
        end
    end

    // A locked CPU that drops its request keeps ownership and its count.
    always_comb begin
        state_nxt = state;
        burst_nxt = burst_cnt;
        if (grant_cpu) begin
            if (state == OWN_CPU) begin
                burst_nxt = burst_inc;
            end else begin
                state_nxt = OWN_CPU;
                burst_nxt = 4'h0;
            end
        end else if (grant_per) begin
            if (state == OWN_PER) begin
                burst_nxt = burst_inc;
            end else begin
                state_nxt = OWN_PER;
                burst_nxt = 4'h0;
            end
        end else if (!locked) begin
            state_nxt = IDLE;
            burst_nxt = 4'h0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            burst_cnt   <= 4'h0;
            last_per    <= 1'b1;
            cpu_rd_pend <= 1'b0;
            per_rd_pend <= 1'b0;
        end else begin
            state       <= state_nxt;
            burst_cnt   <= burst_nxt;
            if (grant_cpu)      last_per <= 1'b0;
            else if (grant_per) last_per <= 1'b1;
            cpu_rd_pend <= grant_cpu && !cpu_we;
            per_rd_pend <= grant_per && !per_we;
        end
    end

    assign cpu_gnt    = grant_cpu;
    assign per_gnt    = grant_per;
    assign mem_en     = grant_cpu | grant_per;
    assign mem_we     = (grant_cpu & cpu_we) | (grant_per & per_we);
    assign mem_addr   = ({ADDR_W{grant_cpu}} & cpu_addr)  | ({ADDR_W{grant_per}} & per_addr);
    assign mem_wdata  = ({DATA_W{grant_cpu}} & cpu_wdata) | ({DATA_W{grant_per}} & per_wdata);

    assign cpu_rvalid = cpu_rd_pend;
    assign per_rvalid = per_rd_pend;
    assign cpu_rdata  = cpu_rd_pend ? mem_rdata : '0;
    assign per_rdata  = per_rd_pend ? mem_rdata : '0;
    assign busy       = (state != IDLE);

endmodule
